game_fsm_timed: RTL and testbench

- Parametrised successor to the single-round game state machine. Owns its own round timer, pre-start countdown, pause, score accumulation and session high score.
- Sits between the debounced button/tick logic and the display drivers. Runs entirely on clkIn; the 1 Hz timebase arrives as a single-cycle enable pulse, not as a second clock.

---
 rtl/game_fsm_timed.sv | 142 ++++++++++++++
 tb/tb_game_fsm_timed.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_timed.sv
// Timed single-player game controller: pre-start countdown, round timer, pause,
// saturating score and session high score. Single clock, 1 Hz tick arrives as an enable.
module game_fsm_timed #(
   parameter int GAME_SECONDS     = 30,
   parameter int PRESTART_SECONDS = 3,
   parameter int TIMER_W          = 6,
   parameter int SCORE_W          = 6
) (
   input  logic               clkIn,
   input  logic               reset,
   input  logic               incrementTick,
   input  logic               startGame,
   input  logic               pauseToggle,
   input  logic               player_scored,
   output logic               game_active,
   output logic               game_paused,
   output logic               countdown_active,
   output logic               game_over,
   output logic [TIMER_W-1:0] time_left,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_high,
   output logic [2:0]         state
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRESTART = 3'd1;
   localparam logic [2:0] S_RUNNING  = 3'd2;
   localparam logic [2:0] S_PAUSED   = 3'd3;
   localparam logic [2:0] S_FINISH   = 3'd4;

   localparam logic [TIMER_W-1:0] GAME_T    = TIMER_W'(GAME_SECONDS);
   localparam logic [TIMER_W-1:0] PRE_T     = TIMER_W'(PRESTART_SECONDS);
   localparam logic [TIMER_W-1:0] ONE_T     = TIMER_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic [2:0]         state_reg, state_next;
   logic [TIMER_W-1:0] time_left_reg, time_left_next;
   logic [SCORE_W-1:0] score_reg, score_next;
   logic [SCORE_W-1:0] high_score_reg, high_score_next;
   logic               new_high_reg, new_high_next;
   // flag order: {game_over, countdown_active, game_paused, game_active}
   logic [3:0]         flags_reg, flags_next;

   always_ff @(posedge clkIn) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         time_left_reg  <= '0;
         score_reg      <= '0;
         high_score_reg <= '0;
         new_high_reg   <= 1'b0;
         flags_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         time_left_reg  <= time_left_next;
         score_reg      <= score_next;
         high_score_reg <= high_score_next;
         new_high_reg   <= new_high_next;
         flags_reg      <= flags_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      time_left_next  = time_left_reg;
      score_next      = score_reg;
      high_score_next = high_score_reg;
      new_high_next   = new_high_reg;

      if (startGame) begin
         score_next    = '0;
         new_high_next = 1'b0;
         if (PRESTART_SECONDS > 0) begin
            state_next     = S_PRESTART;
            time_left_next = PRE_T;
         end else begin
            state_next     = S_RUNNING;
            time_left_next = GAME_T;
         end
      end else begin
         case (state_reg)
            S_IDLE: ;
            S_PRESTART: begin
               if (incrementTick) begin
                  if (time_left_reg <= ONE_T) begin
                     state_next     = S_RUNNING;
                     time_left_next = GAME_T;
                  end else begin
                     time_left_next = time_left_reg - ONE_T;
                  end
               end
            end
            S_RUNNING: begin
               if (pauseToggle) begin
                  state_next = S_PAUSED;
               end else begin
                  if (player_scored && (score_reg != SCORE_MAX))
                     score_next = score_reg + 1'b1;
                  // the final tick compares against the score including this cycle's point
                  if (incrementTick) begin
                     if (time_left_reg <= ONE_T) begin
                        state_next     = S_FINISH;
                        time_left_next = '0;
                        if (score_next > high_score_reg) begin
                           high_score_next = score_next;
                           new_high_next   = 1'b1;
                        end
                     end else begin
                        time_left_next = time_left_reg - ONE_T;
                     end
                  end
               end
            end
            S_PAUSED: begin
               if (pauseToggle)
                  state_next = S_RUNNING;
            end
            S_FINISH: ;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      flags_next    = '0;
      flags_next[0] = (state_next == S_RUNNING);
      flags_next[1] = (state_next == S_PAUSED);
      flags_next[2] = (state_next == S_PRESTART);
      flags_next[3] = (state_next == S_FINISH);
   end

   assign game_active      = flags_reg[0];
   assign game_paused      = flags_reg[1];
   assign countdown_active = flags_reg[2];
   assign game_over        = flags_reg[3];
   assign time_left        = time_left_reg;
   assign score            = score_reg;
   assign high_score       = high_score_reg;
   assign new_high         = new_high_reg;
   assign state            = state_reg;

endmodule

// File: tb/tb_game_fsm_timed.sv
// Drives two game_fsm_timed instances (with and without countdown) from shared inputs
// and checks every cycle against a phase/counter reference model.
module tb_game_fsm_timed;

   logic clk = 1'b0;
   logic rst, tick, start, pause, scored;
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   logic [2:0] st_o [2];
   logic [5:0] tl_o [2];
   logic [3:0] sc_o [2];
   logic [3:0] hi_o [2];
   logic       act_o [2];
   logic       pau_o [2];
   logic       cd_o [2];
   logic       ov_o [2];
   logic       nh_o [2];

   always #5 clk = ~clk;

   game_fsm_timed #(.GAME_SECONDS(5), .PRESTART_SECONDS(3), .TIMER_W(6), .SCORE_W(4)) dut_a (
      .clkIn(clk), .reset(rst), .incrementTick(tick), .startGame(start),
      .pauseToggle(pause), .player_scored(scored),
      .game_active(act_o[0]), .game_paused(pau_o[0]), .countdown_active(cd_o[0]),
      .game_over(ov_o[0]), .time_left(tl_o[0]), .score(sc_o[0]),
      .high_score(hi_o[0]), .new_high(nh_o[0]), .state(st_o[0])
   );

   game_fsm_timed #(.GAME_SECONDS(5), .PRESTART_SECONDS(0), .TIMER_W(6), .SCORE_W(4)) dut_b (
      .clkIn(clk), .reset(rst), .incrementTick(tick), .startGame(start),
      .pauseToggle(pause), .player_scored(scored),
      .game_active(act_o[1]), .game_paused(pau_o[1]), .countdown_active(cd_o[1]),
      .game_over(ov_o[1]), .time_left(tl_o[1]), .score(sc_o[1]),
      .high_score(hi_o[1]), .new_high(nh_o[1]), .state(st_o[1])
   );

   // reference model: phase 0 idle, 1 countdown, 2 playing, 3 paused, 4 over
   int gs [2] = '{5, 5};
   int ps [2] = '{3, 0};
   int smax = 15;
   int m_ph [2];
   int m_t  [2];
   int m_sc [2];
   int m_hi [2];
   int m_nh [2];

   task automatic model_step(input int k);
      if (rst) begin
         m_ph[k] = 0; m_t[k] = 0; m_sc[k] = 0; m_hi[k] = 0; m_nh[k] = 0;
      end else if (start) begin
         m_sc[k] = 0; m_nh[k] = 0;
         m_ph[k] = (ps[k] > 0) ? 1 : 2;
         m_t[k]  = (ps[k] > 0) ? ps[k] : gs[k];
      end else if (m_ph[k] == 1) begin
         if (tick) begin
            m_t[k] = m_t[k] - 1;
            if (m_t[k] == 0) begin
               m_ph[k] = 2;
               m_t[k]  = gs[k];
            end
         end
      end else if (m_ph[k] == 2) begin
         if (pause) m_ph[k] = 3;
         else begin
            if (scored) m_sc[k] = (m_sc[k] + 1 > smax) ? smax : m_sc[k] + 1;
            if (tick) m_t[k] = m_t[k] - 1;
            if (m_t[k] == 0) begin
               m_ph[k] = 4;
               if (m_sc[k] > m_hi[k]) begin
                  m_hi[k] = m_sc[k];
                  m_nh[k] = 1;
               end
            end
         end
      end else if (m_ph[k] == 3) begin
         if (pause) m_ph[k] = 2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         string p;
         p = (k == 0) ? "a" : "b";
         chk({p, ".state"}, 32'(st_o[k]), 32'(m_ph[k]));
         chk({p, ".time_left"}, 32'(tl_o[k]), 32'(m_t[k]));
         chk({p, ".score"}, 32'(sc_o[k]), 32'(m_sc[k]));
         chk({p, ".high_score"}, 32'(hi_o[k]), 32'(m_hi[k]));
         chk({p, ".new_high"}, 32'(nh_o[k]), 32'(m_nh[k]));
         chk({p, ".game_active"}, 32'(act_o[k]), 32'(m_ph[k] == 2));
         chk({p, ".game_paused"}, 32'(pau_o[k]), 32'(m_ph[k] == 3));
         chk({p, ".countdown"}, 32'(cd_o[k]), 32'(m_ph[k] == 1));
         chk({p, ".game_over"}, 32'(ov_o[k]), 32'(m_ph[k] == 4));
      end
   endtask

   // one transaction: drive inputs, let one edge pass, update model, compare
   task automatic cyc(input logic r, input logic s, input logic p, input logic t, input logic sc);
      rst = r; start = s; pause = p; tick = t; scored = sc;
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
      txn++;
      $display("txn %0d rst=%0b start=%0b pause=%0b tick=%0b scored=%0b | a: st=%0d t=%0d sc=%0d hi=%0d nh=%0b | b: st=%0d t=%0d sc=%0d hi=%0d nh=%0b",
               txn, r, s, p, t, sc, st_o[0], tl_o[0], sc_o[0], hi_o[0], nh_o[0],
               st_o[1], tl_o[1], sc_o[1], hi_o[1], nh_o[1]);
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
   endtask

   task automatic scores(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0; scored = 1'b0;
      @(negedge clk);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("reset.state", 32'(st_o[0]), 0);
      chk("reset.score", 32'(sc_o[0]), 0);

      // countdown then round
      cyc(0, 1, 0, 0, 0);
      chk("start.countdown", 32'(cd_o[0]), 1);
      chk("start.time", 32'(tl_o[0]), 3);
      chk("b.start_direct", 32'(st_o[1]), 2);
      ticks(3);
      chk("prestart_done.state", 32'(st_o[0]), 2);
      chk("prestart_done.time", 32'(tl_o[0]), 5);
      scores(20);
      chk("saturate.score", 32'(sc_o[0]), 15);
      ticks(5);
      chk("finish.over", 32'(ov_o[0]), 1);
      chk("finish.time", 32'(tl_o[0]), 0);
      chk("finish.high", 32'(hi_o[0]), 15);
      chk("finish.new_high", 32'(nh_o[0]), 1);

      // pause freezes time and score
      cyc(0, 1, 0, 0, 0);
      ticks(4);
      chk("pre_pause.time", 32'(tl_o[0]), 4);
      cyc(0, 0, 1, 1, 0);
      ticks(3);
      scores(2);
      chk("paused.time", 32'(tl_o[0]), 4);
      chk("paused.score", 32'(sc_o[0]), 0);
      chk("paused.flag", 32'(pau_o[0]), 1);
      cyc(0, 0, 1, 0, 0);
      ticks(1);
      chk("resume.time", 32'(tl_o[0]), 3);

      // last tick and score together; then equal score does not set new_high
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      ticks(3);
      scores(6);
      ticks(4);
      cyc(0, 0, 0, 1, 1);
      chk("last_tick.score", 32'(sc_o[0]), 7);
      chk("last_tick.high", 32'(hi_o[0]), 7);
      chk("last_tick.over", 32'(ov_o[0]), 1);
      cyc(0, 1, 0, 0, 0);
      chk("restart.new_high_clear", 32'(nh_o[0]), 0);
      ticks(3);
      scores(7);
      ticks(5);
      chk("equal.new_high", 32'(nh_o[0]), 0);
      chk("equal.high", 32'(hi_o[0]), 7);

      // restart beats pause on the no-countdown instance
      cyc(0, 1, 0, 0, 0);
      scores(3);
      cyc(0, 1, 1, 1, 1);
      chk("b.restart.score", 32'(sc_o[1]), 0);
      chk("b.restart.paused", 32'(pau_o[1]), 0);
      chk("b.restart.time", 32'(tl_o[1]), 5);

      // reset mid-round
      cyc(0, 1, 0, 0, 0);
      ticks(3);
      scores(9);
      chk("mid.score", 32'(sc_o[0]), 9);
      cyc(1, 0, 0, 0, 0);
      chk("mid_reset.state", 32'(st_o[0]), 0);
      chk("mid_reset.score", 32'(sc_o[0]), 0);
      chk("mid_reset.high", 32'(hi_o[0]), 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
